// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode constants, state encodings and the set-2 to ASCII lookup (US layout).
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;

  localparam logic [7:0] KEY_LINEFEED = 8'h0A;
  localparam logic [7:0] KEY_BKSP     = 8'h08;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {DEC_IDLE, DEC_E0, DEC_F0, DEC_E0F0} dec_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] ch;
  } key_lut_t;

  // pair holds {unshifted, shifted}; letters follow shift^caps, everything else follows shift only
  function automatic key_lut_t sc_to_ascii(input logic [7:0] sc, input logic shift, input logic caps);
    key_lut_t   r;
    logic [15:0] pair;
    logic       is_letter;
    r.valid = 1'b1;
    pair    = 16'h0000;
    case (sc)
      8'h1C: pair = {"a", "A"};   8'h32: pair = {"b", "B"};
      8'h21: pair = {"c", "C"};   8'h23: pair = {"d", "D"};
      8'h24: pair = {"e", "E"};   8'h2B: pair = {"f", "F"};
      8'h34: pair = {"g", "G"};   8'h33: pair = {"h", "H"};
      8'h43: pair = {"i", "I"};   8'h3B: pair = {"j", "J"};
      8'h42: pair = {"k", "K"};   8'h4B: pair = {"l", "L"};
      8'h3A: pair = {"m", "M"};   8'h31: pair = {"n", "N"};
      8'h44: pair = {"o", "O"};   8'h4D: pair = {"p", "P"};
      8'h15: pair = {"q", "Q"};   8'h2D: pair = {"r", "R"};
      8'h1B: pair = {"s", "S"};   8'h2C: pair = {"t", "T"};
      8'h3C: pair = {"u", "U"};   8'h2A: pair = {"v", "V"};
      8'h1D: pair = {"w", "W"};   8'h22: pair = {"x", "X"};
      8'h35: pair = {"y", "Y"};   8'h1A: pair = {"z", "Z"};
      8'h45: pair = {"0", ")"};   8'h16: pair = {"1", "!"};
      8'h1E: pair = {"2", "@"};   8'h26: pair = {"3", "#"};
      8'h25: pair = {"4", "$"};   8'h2E: pair = {"5", "%"};
      8'h36: pair = {"6", "^"};   8'h3D: pair = {"7", "&"};
      8'h3E: pair = {"8", "*"};   8'h46: pair = {"9", "("};
      8'h0E: pair = {8'h60, "~"}; 8'h4E: pair = {"-", "_"};
      8'h55: pair = {"=", "+"};   8'h54: pair = {"[", "{"};
      8'h5B: pair = {"]", "}"};   8'h5D: pair = {"\\", "|"};
      8'h4C: pair = {";", ":"};   8'h52: pair = {"'", "\""};
      8'h41: pair = {",", "<"};   8'h49: pair = {".", ">"};
      8'h4A: pair = {"/", "?"};
      SC_SPACE: pair = {8'h20, 8'h20};
      SC_ENTER: pair = {KEY_LINEFEED, KEY_LINEFEED};
      SC_BKSP:  pair = {KEY_BKSP, KEY_BKSP};
      default:  r.valid = 1'b0;
    endcase
    is_letter = (pair[15:8] >= "a") && (pair[15:8] <= "z");
    r.ch = (is_letter ? (shift ^ caps) : shift) ? pair[7:0] : pair[15:8];
    return r;
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 pins in, decoded key stream out; slave is the decoder side.
interface ps2_key_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key;
  logic       key_valid;
  logic       frame_err;
  logic       caps_lock;

  modport master (output ps2_clk, ps2_data, input key, key_valid, frame_err, caps_lock);
  modport slave  (input ps2_clk, ps2_data, output key, key_valid, frame_err, caps_lock);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk glitch filter, 11-bit frame FSM and stall timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 10000,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          clk_f_q, clk_f_d;
  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  rx_state_e     state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          strobe_c;

  always_comb begin
    clk_f_d     = clk_f_q;
    flt_cnt_d   = flt_cnt_q;
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    par_d       = par_q;
    tmo_d       = tmo_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    strobe_c    = 1'b0;

    // filtered clock flips after FILTER_LEN consecutive differing samples; a flip to 0 is the strobe
    if (clk_s2_q != clk_f_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        clk_f_d   = clk_s2_q;
        flt_cnt_d = '0;
        strobe_c  = ~clk_s2_q;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end else begin
      flt_cnt_d = '0;
    end

    if (state_q == RX_IDLE || strobe_c) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      tmo_d       = '0;
      state_d     = RX_IDLE;
      frame_err_d = 1'b1;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end

    if (strobe_c) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = dat_s2_q;
          state_d = RX_STOP;
        end
        default: begin
          state_d = RX_IDLE;
          if (dat_s2_q && (^{shreg_q, par_q})) begin
            rx_valid_d = 1'b1;
            rx_byte_d  = shreg_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      clk_f_q     <= 1'b1;
      flt_cnt_q   <= '0;
      state_q     <= RX_IDLE;
      shreg_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      clk_f_q     <= clk_f_d;
      flt_cnt_q   <= flt_cnt_d;
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to ASCII: prefix tracking (E0/F0), Shift/Caps state and one key pulse per press.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 10000,
  parameter int unsigned FILTER_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_decoder_if.slave bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_frame_err;

  ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC), .FILTER_LEN(FILTER_LEN)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .frame_err(rx_frame_err)
  );

  dec_state_e dec_q, dec_d;
  logic [7:0] key_q, key_d;
  logic       key_valid_q, key_valid_d;
  logic       caps_q, caps_d;
  logic       lshift_q, lshift_d;
  logic       rshift_q, rshift_d;
  key_lut_t   lut_c;

  always_comb begin
    dec_d       = dec_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    caps_d      = caps_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lut_c       = sc_to_ascii(rx_byte, lshift_q | rshift_q, caps_q);

    if (rx_valid) begin
      case (dec_q)
        DEC_IDLE: begin
          if (rx_byte == SC_EXT)             dec_d = DEC_E0;
          else if (rx_byte == SC_BREAK)      dec_d = DEC_F0;
          else if (rx_byte == SC_LSHIFT)     lshift_d = 1'b1;
          else if (rx_byte == SC_RSHIFT)     rshift_d = 1'b1;
          else if (rx_byte == SC_CAPS)       caps_d = ~caps_q;
          else if (lut_c.valid) begin
            key_d       = lut_c.ch;
            key_valid_d = 1'b1;
          end
        end
        DEC_E0: begin
          if (rx_byte == SC_BREAK) begin
            dec_d = DEC_E0F0;
          end else begin
            dec_d = DEC_IDLE;
            if (rx_byte == SC_ENTER) begin
              key_d       = KEY_LINEFEED;
              key_valid_d = 1'b1;
            end
          end
        end
        // shift stays asserted while either side is still held
        DEC_F0: begin
          dec_d = DEC_IDLE;
          if (rx_byte == SC_LSHIFT) lshift_d = 1'b0;
          if (rx_byte == SC_RSHIFT) rshift_d = 1'b0;
        end
        default: dec_d = DEC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q       <= DEC_IDLE;
      key_q       <= 8'h00;
      key_valid_q <= 1'b0;
      caps_q      <= 1'b0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      caps_q      <= caps_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
    end
  end

  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.frame_err = rx_frame_err;
  assign bus.caps_lock = caps_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: drives PS/2 frames, scoreboards key pulses.
module tb_ps2_key_decoder;

  localparam int unsigned TMO  = 200;
  localparam int unsigned FLT  = 4;
  localparam int          HALF = 12;

  logic clk;
  logic rst;
  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYC(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         last_strobe = 0;
  int         last_kv = 0;
  int         kv_pulses = 0;
  int         err_pulses = 0;
  logic [7:0] exp_q[$];

  // one clock step; sampled at negedge, pops the scoreboard on every key pulse
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    if (dut.u_rx.strobe_c) last_strobe = cyc;
    if (bus.frame_err) err_pulses++;
    if (bus.key_valid) begin
      kv_pulses++;
      last_kv = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_key got=%h expected=no pulse", bus.key);
      end else begin
        e = exp_q.pop_front();
        if (bus.key !== e) begin
          errors++;
          $display("FAIL key_value got=%h expected=%h", bus.key, e);
        end
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = bits[i];
      wait_cyc(HALF);
      bus.ps2_clk = 1'b0;
      wait_cyc(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip_par, input logic bad_stop);
    logic par;
    par = ~(^b) ^ flip_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk_frame(b, 1'b0, 1'b0), 11);
    wait_cyc(HALF);
  endtask

  task automatic press(input logic [7:0] b, input logic [7:0] exp_ch);
    exp_q.push_back(exp_ch);
    send_byte(b);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing_pulses got=%0d expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cyc(4);
    checks++; if (bus.key !== 8'h00)      begin errors++; $display("FAIL reset_key got=%h expected=00", bus.key); end
    checks++; if (bus.key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid got=%b expected=0", bus.key_valid); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b expected=0", bus.frame_err); end
    checks++; if (bus.caps_lock !== 1'b0) begin errors++; $display("FAIL reset_caps got=%b expected=0", bus.caps_lock); end
    rst = 1'b0;
    wait_cyc(10);
  endtask

  task automatic test_basic_latency();
    int kv0;
    kv0 = kv_pulses;
    press(8'h1C, 8'h61);
    checks++; if (last_kv - last_strobe !== 2) begin errors++; $display("FAIL latency got=%0d expected=2", last_kv - last_strobe); end
    checks++; if (kv_pulses !== kv0 + 1) begin errors++; $display("FAIL pulse_width got=%0d expected=1", kv_pulses - kv0); end
    checks++; if (bus.key !== 8'h61) begin errors++; $display("FAIL key_hold got=%h expected=61", bus.key); end
    kv0 = kv_pulses;
    send_byte(8'hF0); send_byte(8'h1C);
    checks++; if (kv_pulses !== kv0) begin errors++; $display("FAIL break_no_pulse got=%0d expected=0", kv_pulses - kv0); end
    check_drained("basic");
  endtask

  task automatic test_shift();
    send_byte(8'h12);
    press(8'h1C, 8'h41);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    press(8'h1C, 8'h61);
    press(8'h1C, 8'h61);
    send_byte(8'h12); send_byte(8'h59);
    send_byte(8'hF0); send_byte(8'h12);
    press(8'h1C, 8'h41);
    send_byte(8'hF0); send_byte(8'h59);
    press(8'h1C, 8'h61);
    check_drained("shift");
  endtask

  task automatic test_caps();
    send_byte(8'h58);
    checks++; if (bus.caps_lock !== 1'b1) begin errors++; $display("FAIL caps_on got=%b expected=1", bus.caps_lock); end
    press(8'h16, 8'h31);
    press(8'h1C, 8'h41);
    send_byte(8'h12);
    press(8'h16, 8'h21);
    press(8'h1C, 8'h61);
    press(8'h4A, 8'h3F);
    send_byte(8'hF0); send_byte(8'h12);
    send_byte(8'h58);
    checks++; if (bus.caps_lock !== 1'b0) begin errors++; $display("FAIL caps_off got=%b expected=0", bus.caps_lock); end
    press(8'h52, 8'h27);
    check_drained("caps");
  endtask

  task automatic test_special();
    press(8'h5A, 8'h0A);
    exp_q.push_back(8'h0A); send_byte(8'hE0); send_byte(8'h5A);
    send_byte(8'hE0); send_byte(8'h75);
    press(8'h1C, 8'h61);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h5A);
    press(8'h29, 8'h20);
    press(8'h66, 8'h08);
    send_byte(8'h76);
    press(8'h45, 8'h30);
    check_drained("special");
  endtask

  task automatic test_frame_errors();
    int e0, kv0;
    e0 = err_pulses; kv0 = kv_pulses;
    send_bits(mk_frame(8'h1C, 1'b1, 1'b0), 11); wait_cyc(HALF);
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL parity_err got=%0d expected=1", err_pulses - e0); end
    send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    bus.ps2_data = 1'b1;
    wait_cyc(HALF);
    checks++; if (err_pulses !== e0 + 2) begin errors++; $display("FAIL stop_err got=%0d expected=2", err_pulses - e0); end
    checks++; if (kv_pulses !== kv0) begin errors++; $display("FAIL err_no_key got=%0d expected=0", kv_pulses - kv0); end
    press(8'h1C, 8'h61);
    check_drained("frame_err");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_pulses;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 5);
    wait_cyc(int'(TMO) + 10);
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL timeout_err got=%0d expected=1", err_pulses - e0); end
    press(8'h45, 8'h30);
    checks++; if (err_pulses !== e0 + 1) begin errors++; $display("FAIL timeout_recover got=%0d expected=1", err_pulses - e0); end
    check_drained("timeout");
  endtask

  task automatic test_reset_midframe();
    int e0, kv0;
    send_byte(8'h58);
    send_byte(8'h12);
    e0 = err_pulses; kv0 = kv_pulses;
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 4);
    rst = 1'b1;
    wait_cyc(3);
    checks++; if (bus.key !== 8'h00)      begin errors++; $display("FAIL midrst_key got=%h expected=00", bus.key); end
    checks++; if (bus.caps_lock !== 1'b0) begin errors++; $display("FAIL midrst_caps got=%b expected=0", bus.caps_lock); end
    checks++; if (bus.key_valid !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_pulses got=%b%b expected=00", bus.key_valid, bus.frame_err);
    end
    rst = 1'b0;
    wait_cyc(int'(TMO) + 10);
    press(8'h1C, 8'h61);
    checks++; if (err_pulses !== e0 || kv_pulses !== kv0 + 1) begin
      errors++; $display("FAIL midrst_after got=err%0d/key%0d expected=err0/key1", err_pulses - e0, kv_pulses - kv0);
    end
    check_drained("midrst");
  endtask

  task automatic test_back_to_back();
    press(8'h1C, 8'h61);
    press(8'h1C, 8'h61);
    press(8'h1C, 8'h61);
    press(8'h32, 8'h62);
    check_drained("back_to_back");
  endtask

  initial begin
    rst = 1'b1;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_basic_latency();
    test_shift();
    test_caps();
    test_special();
    test_frame_errors();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
Upstream feeder of the keyboard line buffer. Receives raw PS/2 keyboard frames on the ps2_clk/ps2_data pins and tracks the make, break and extended prefixes plus Shift and Caps Lock state. Emits one ASCII byte per key press on key/key_valid, the exact interface the line buffer consumes. Enter is translated to linefeed 0x0A, which is the line-commit code downstream.

Parameters:
TIMEOUT_CYC, 10000, clk cycles without a PS/2 falling edge before a partial frame is abandoned (100 us at 100 MHz).
FILTER_LEN, 4, consecutive identical synchronized samples required before ps2_clk is considered changed (glitch filter).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
ps2_clk  input  1  PS/2 clock from the keyboard; asynchronous.
ps2_data  input  1  PS/2 data from the keyboard; asynchronous.
key  output  8  ASCII code; valid only while key_valid=1.
key_valid  output  1  one-cycle pulse per decoded key press.
frame_err  output  1  one-cycle pulse on a parity, start or stop error, or on a timeout.
caps_lock  output  1  current Caps Lock state.

Behaviour:
- Reset on rst: key=0x00, key_valid=0, frame_err=0, caps_lock=0, shift=0, receiver IDLE, decoder IDLE, timeout counter cleared.
- Reset mid-frame discards all partial bits; no pulse is emitted.
- Input conditioning: 2-FF synchronizer on each pin. The filtered ps2_clk changes only after FILTER_LEN equal samples. A falling edge of the filtered clock is the sample strobe; ps2_data is sampled from its synchronizer on that strobe.
- Receiver FSM, states IDLE, DATA, PARITY, STOP:
  - IDLE: on a strobe, data=0 goes to DATA; data=1 is ignored and the FSM stays in IDLE.
  - DATA: shifts in 8 bits, LSB first, then goes to PARITY.
  - PARITY: checks odd parity over data plus parity bit, then goes to STOP.
  - STOP: stop bit must be 1.
  - Good frame: rx_valid pulses for one cycle the cycle after the stop strobe, carrying rx_byte.
  - Bad parity or stop bit = 0: frame_err pulses the cycle after the stop strobe, no rx_valid, return to IDLE.
- Timeout: the counter resets on every strobe and counts only outside IDLE. Reaching TIMEOUT_CYC forces IDLE and pulses frame_err once.
- Decoder FSM, states IDLE, E0, F0, E0F0, advanced on rx_valid:
  - IDLE: 0xE0 goes to E0; 0xF0 goes to F0; any other byte is a make code, then IDLE.
  - E0: 0xF0 goes to E0F0; any other byte is an extended make, then IDLE.
  - F0: byte is a break code, then IDLE.
  - E0F0: byte is an extended break, then IDLE.
- Make-code actions:
  - 0x12/0x59 (L/R Shift): shift=1, no output.
  - 0x58: toggles caps_lock, no output.
  - Mapped code: key=table(code, shift, caps_lock), key_valid=1.
  - Unmapped code: no output.
- Break-code actions: 0x12/0x59 set shift=0 only if the other Shift is not held (two held bits). All other breaks produce no output.
- Extended make: E0 5A (keypad Enter) outputs 0x0A. All other extended codes produce no output.
- Mapping, US layout:
  - Letters: lower case when shift XOR caps_lock=0, upper case otherwise.
  - Digits and punctuation: use the shifted glyph when shift=1; caps_lock has no effect.
  - 0x29 gives 0x20 (space); 0x5A gives 0x0A; 0x66 gives 0x08 (backspace).
- Latency: key_valid is registered and asserts exactly 2 clk cycles after the stop-bit strobe (rx_valid at +1, key at +2).
- key holds its value after the pulse.
- Typematic repeats (repeated make codes) each produce a pulse.
- If rx_valid and a timeout coincide, the timeout is impossible (counter reset by the strobe); no arbitration is needed.

Decomposition:
- Shared package ps2_pkg holds:
  - Scancode constants: SC_EXT=0xE0, SC_BREAK=0xF0, SC_LSHIFT=0x12, SC_RSHIFT=0x59, SC_CAPS=0x58, SC_ENTER=0x5A, SC_BKSP=0x66, SC_SPACE=0x29.
  - ASCII constants: KEY_LINEFEED=0x0A, KEY_BKSP=0x08.
  - Receiver and decoder state encodings.
  - The scancode-to-ASCII lookup function.
- One natural sub-module, ps2_rx: synchronizer, filter, frame FSM and timeout. It outputs rx_byte, rx_valid and frame_err.
- The decoder FSM and lookup stay in the top level.

Test Plan:
- Frame 0x1C (odd parity ok) -> key=0x61, key_valid high 1 cycle, 2 cycles after the stop strobe. Then F0, 1C -> no pulse.
- 0x12, 0x1C, F0 1C, F0 12, 0x1C -> pulses 0x41 then 0x61. 0x58 then 0x16 -> caps_lock=1, key=0x31; 0x12, 0x16 -> 0x21.
- 0x5A -> 0x0A. E0 5A -> 0x0A. E0 75 (arrow) -> no pulse, decoder back in IDLE; next 0x1C -> 0x61.
- Frame 0x1C with the parity bit flipped -> frame_err pulse, no key_valid. Stop bit = 0 -> same.
- 5 bits of a frame, then idle for TIMEOUT_CYC+10 -> exactly one frame_err pulse. A following good 0x45 -> key=0x30.
- rst asserted after 4 bits and with shift held -> all outputs 0, caps_lock=0. Next 0x1C -> 0x61 (shift cleared).
